// File: rtl/dmem_arbiter_pkg.sv
// Shared widths, counter size and one-hot FSM encodings for the data-memory arbiter.
// Constants only; no timing or flow-control behaviour lives here.
package dmem_arbiter_pkg;

   localparam int LEN_WORD         = 32;
   localparam int LEN_MEMDATA_ADDR = 10;
   localparam int LEN_ARB_CNT      = 3;

   typedef enum logic [3:0] {
      ARB_STATE_IDLE  = 4'b0001,
      ARB_STATE_ISSUE = 4'b0010,
      ARB_STATE_WAIT  = 4'b0100,
      ARB_STATE_RESP  = 4'b1000
   } arb_state_t;

   // An all-zero strobe pattern marks a load.
   function automatic logic is_read(input logic [3:0] we);
      return (we == 4'b0000);
   endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker: on a tie the requester that did not win last time is chosen.
// Zero latency; no backpressure, it only ranks the current requests.
module rr_pick2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       grant_valid,
   output logic       grant_id
);

   always_comb begin
      grant_valid = |req;
      grant_id    = 1'b0;
      if (req == 2'b11)
         grant_id = ~last_grant;
      else if (req[1])
         grant_id = 1'b1;
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between two order/accepted/done requesters, one transaction in flight.
// Accepted 1 cycle after order is sampled; done at A+1 (store) or A+READ_LATENCY+1 (load); orders wait while busy.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int ADDR_W       = LEN_MEMDATA_ADDR,
   parameter int DATA_W       = LEN_WORD,
   parameter int READ_LATENCY = 2
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              r0_order,
   input  logic [ADDR_W-1:0] r0_addr,
   input  logic [DATA_W-1:0] r0_wdata,
   input  logic [3:0]        r0_we,
   output logic              r0_accepted,
   output logic              r0_done,
   output logic [DATA_W-1:0] r0_rdata,
   input  logic              r1_order,
   input  logic [ADDR_W-1:0] r1_addr,
   input  logic [DATA_W-1:0] r1_wdata,
   input  logic [3:0]        r1_we,
   output logic              r1_accepted,
   output logic              r1_done,
   output logic [DATA_W-1:0] r1_rdata,
   output logic [ADDR_W-1:0] a_mem,
   output logic [DATA_W-1:0] sd_mem,
   input  logic [DATA_W-1:0] ld_mem,
   output logic [3:0]        mem_write_flag,
   output logic              mem_read_flag
);

   localparam logic [LEN_ARB_CNT-1:0] CNT_LOAD = LEN_ARB_CNT'(READ_LATENCY - 1);
   localparam logic [LEN_ARB_CNT-1:0] CNT_ONE  = LEN_ARB_CNT'(1);

   arb_state_t             state;
   arb_state_t             state_nxt;
   logic [LEN_ARB_CNT-1:0] cnt;
   logic                   last_grant;
   logic                   owner;
   logic                   rd_q;

   logic                   grant_valid;
   logic                   grant_id;
   logic [ADDR_W-1:0]      g_addr;
   logic [DATA_W-1:0]      g_wdata;
   logic [3:0]             g_we;

   rr_pick2 u_pick (
      .req         ({r1_order, r0_order}),
      .last_grant  (last_grant),
      .grant_valid (grant_valid),
      .grant_id    (grant_id)
   );

   assign g_addr  = grant_id ? r1_addr  : r0_addr;
   assign g_wdata = grant_id ? r1_wdata : r0_wdata;
   assign g_we    = grant_id ? r1_we    : r0_we;

   // The counter already runs during ISSUE, so a load reaches RESP exactly
   // when ld_mem is valid, READ_LATENCY cycles after the read flag.
   always_comb begin
      state_nxt = state;
      case (state)
         ARB_STATE_IDLE: begin
            if (grant_valid)
               state_nxt = ARB_STATE_ISSUE;
         end
         ARB_STATE_ISSUE: begin
            if (!rd_q)
               state_nxt = ARB_STATE_IDLE;
            else if (cnt == '0)
               state_nxt = ARB_STATE_RESP;
            else
               state_nxt = ARB_STATE_WAIT;
         end
         ARB_STATE_WAIT: begin
            if (cnt == '0)
               state_nxt = ARB_STATE_RESP;
         end
         ARB_STATE_RESP: begin
            state_nxt = ARB_STATE_IDLE;
         end
         default: begin
            state_nxt = ARB_STATE_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state          <= ARB_STATE_IDLE;
         cnt            <= '0;
         last_grant     <= 1'b1;
         owner          <= 1'b0;
         rd_q           <= 1'b0;
         r0_accepted    <= 1'b0;
         r1_accepted    <= 1'b0;
         r0_done        <= 1'b0;
         r1_done        <= 1'b0;
         r0_rdata       <= '0;
         r1_rdata       <= '0;
         a_mem          <= '0;
         sd_mem         <= '0;
         mem_write_flag <= '0;
         mem_read_flag  <= 1'b0;
      end else begin
         state          <= state_nxt;
         r0_accepted    <= 1'b0;
         r1_accepted    <= 1'b0;
         r0_done        <= 1'b0;
         r1_done        <= 1'b0;
         mem_write_flag <= '0;
         mem_read_flag  <= 1'b0;
         case (state)
            ARB_STATE_IDLE: begin
               if (grant_valid) begin
                  owner          <= grant_id;
                  last_grant     <= grant_id;
                  rd_q           <= is_read(g_we);
                  cnt            <= CNT_LOAD;
                  a_mem          <= g_addr;
                  sd_mem         <= g_wdata;
                  mem_write_flag <= g_we;
                  mem_read_flag  <= is_read(g_we);
                  r0_accepted    <= ~grant_id;
                  r1_accepted    <= grant_id;
               end
            end
            ARB_STATE_ISSUE: begin
               // Stores complete as soon as the strobes have been presented.
               if (rd_q) begin
                  if (cnt != '0)
                     cnt <= cnt - CNT_ONE;
               end else begin
                  r0_done <= ~owner;
                  r1_done <= owner;
               end
            end
            ARB_STATE_WAIT: begin
               if (cnt != '0)
                  cnt <= cnt - CNT_ONE;
            end
            ARB_STATE_RESP: begin
               if (owner)
                  r1_rdata <= ld_mem;
               else
                  r0_rdata <= ld_mem;
               r0_done <= ~owner;
               r1_done <= owner;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed bench for dmem_arbiter against a timestamp-level transaction model.
// A behavioural memory answers loads READ_LATENCY cycles after the read flag.
module tb_dmem_arbiter;
   import dmem_arbiter_pkg::*;

   localparam int AW = 10;
   localparam int DW = LEN_WORD;
   localparam int RL = 2;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [3:0]    we;
   } req_t;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          ord [2];
   logic [AW-1:0] adr [2];
   logic [DW-1:0] wd  [2];
   logic [3:0]    we  [2];
   logic          acc [2];
   logic          dn  [2];
   logic [DW-1:0] rd  [2];
   logic [AW-1:0] a_mem;
   logic [DW-1:0] sd_mem;
   logic [DW-1:0] ld_mem;
   logic [3:0]    mem_write_flag;
   logic          mem_read_flag;

   always #5 clk = ~clk;

   dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL)) dut (
      .clk(clk), .rstn(rstn),
      .r0_order(ord[0]), .r0_addr(adr[0]), .r0_wdata(wd[0]), .r0_we(we[0]),
      .r0_accepted(acc[0]), .r0_done(dn[0]), .r0_rdata(rd[0]),
      .r1_order(ord[1]), .r1_addr(adr[1]), .r1_wdata(wd[1]), .r1_we(we[1]),
      .r1_accepted(acc[1]), .r1_done(dn[1]), .r1_rdata(rd[1]),
      .a_mem(a_mem), .sd_mem(sd_mem), .ld_mem(ld_mem),
      .mem_write_flag(mem_write_flag), .mem_read_flag(mem_read_flag)
   );

   int            n_vec = 0;
   int            n_bad = 0;
   int            cyc = 0;
   logic          rst_next = 1'b0;
   req_t          q0 [$];
   req_t          q1 [$];
   bit            infl [2];

   logic [DW-1:0] mem  [0:1023];
   logic [DW-1:0] refm [0:1023];
   bit            hv [0:7];
   logic [DW-1:0] hd [0:7];

   // Reference model: the outstanding transaction is described only by who owns it and when it ends.
   bit            busy;
   int            t_done;
   bit            own;
   bit            m_rd;
   bit            last;
   logic [DW-1:0] rd_val;
   bit            e_acc [2];
   bit            e_dn  [2];
   logic [3:0]    e_wf;
   bit            e_rf;
   logic [AW-1:0] e_a;
   logic [DW-1:0] e_sd;
   logic [DW-1:0] e_rd [2];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, exp);
      end
   endtask

   task automatic push(input int id, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] w);
      req_t r;
      r.addr = a; r.wdata = d; r.we = w;
      if (id == 0) q0.push_back(r);
      else         q1.push_back(r);
   endtask

   task automatic model_step();
      bit w;
      for (int i = 0; i < 2; i++) begin e_acc[i] = 0; e_dn[i] = 0; end
      e_wf = 4'h0;
      e_rf = 1'b0;
      if (!rstn) begin
         busy = 0; last = 1; e_a = '0; e_sd = '0; e_rd[0] = '0; e_rd[1] = '0;
         return;
      end
      if (busy && cyc + 1 == t_done) begin
         e_dn[own] = 1;
         if (m_rd) e_rd[own] = rd_val;
      end
      if (busy && cyc == t_done) busy = 0;
      if (!busy && (ord[0] || ord[1])) begin
         w = (ord[0] && ord[1]) ? !last : ord[1];
         last = w; own = w; busy = 1;
         m_rd = (we[w] == 4'b0000);
         t_done = cyc + 1 + (m_rd ? RL + 1 : 1);
         e_acc[w] = 1;
         e_a = adr[w]; e_sd = wd[w]; e_wf = we[w]; e_rf = m_rd;
         if (m_rd) rd_val = refm[adr[w]];
         else for (int b = 0; b < 4; b++)
            if (we[w][b]) refm[adr[w]][b*8 +: 8] = wd[w][b*8 +: 8];
      end
   endtask

   task automatic cycle();
      req_t r;
      @(negedge clk);
      cyc++;
      check("hs", {56'd0, acc[0], dn[0], acc[1], dn[1], mem_read_flag, mem_write_flag},
                  {56'd0, e_acc[0], e_dn[0], e_acc[1], e_dn[1], e_rf, e_wf});
      check("a_mem", 64'(a_mem), 64'(e_a));
      check("sd_mem", 64'(sd_mem), 64'(e_sd));
      check("r0_rdata", 64'(rd[0]), 64'(e_rd[0]));
      check("r1_rdata", 64'(rd[1]), 64'(e_rd[1]));
      // Memory: stores land at the end of this cycle; load data is valid only in cycle read+RL.
      for (int b = 0; b < 4; b++)
         if (mem_write_flag[b]) mem[a_mem][b*8 +: 8] = sd_mem[b*8 +: 8];
      for (int k = 7; k > 0; k--) begin hv[k] = hv[k-1]; hd[k] = hd[k-1]; end
      hv[0] = (mem_read_flag === 1'b1);
      hd[0] = mem[a_mem];
      ld_mem = hv[RL] ? hd[RL] : $urandom;
      rstn = rst_next;
      for (int i = 0; i < 2; i++) begin
         if (!rstn) begin
            ord[i] = 0; infl[i] = 0;
         end else begin
            if (acc[i] === 1'b1) begin infl[i] = 1; ord[i] = 0; end
            if (dn[i] === 1'b1) infl[i] = 0;
            if (!infl[i] && !ord[i] && ((i == 0) ? q0.size() : q1.size()) != 0) begin
               r = (i == 0) ? q0.pop_front() : q1.pop_front();
               ord[i] = 1; adr[i] = r.addr; wd[i] = r.wdata; we[i] = r.we;
            end
         end
      end
      model_step();
   endtask

   task automatic drain();
      int k = 0;
      while ((q0.size() != 0 || q1.size() != 0 || ord[0] || ord[1] || infl[0] || infl[1]) && k < 300) begin
         cycle();
         k++;
      end
      check("drain_timeout", 64'(k < 300), 64'd1);
      cycle();
   endtask

   task automatic pulse_reset();
      rst_next = 0; cycle();
      rst_next = 1; cycle();
   endtask

   function automatic logic [3:0] rand_we();
      case ($urandom_range(0, 5))
         3:       return 4'hF;
         4:       return 4'h1 << $urandom_range(0, 3);
         5:       return 4'($urandom_range(1, 15));
         default: return 4'h0;
      endcase
   endfunction

   initial begin
      for (int i = 0; i < 1024; i++) begin mem[i] = $urandom; refm[i] = mem[i]; end
      mem[16] = 32'hDEADBEEF; refm[16] = 32'hDEADBEEF;
      for (int k = 0; k < 8; k++) begin hv[k] = 0; hd[k] = '0; end
      for (int i = 0; i < 2; i++) begin ord[i] = 0; adr[i] = '0; wd[i] = '0; we[i] = '0; infl[i] = 0; end
      ld_mem = '0;
      rstn = 0; rst_next = 0;
      model_step();
      repeat (3) cycle();
      rst_next = 1;
      cycle();

      push(0, 10'h010, 32'h0, 4'b0000);
      drain();
      check("dir_r0_load", 64'(rd[0]), 64'hDEADBEEF);

      push(1, 10'h020, 32'h12345678, 4'b1111);
      drain();
      check("dir_r1_store", 64'(mem[32]), 64'h12345678);

      pulse_reset();
      for (int n = 0; n < 9; n++) begin
         push(0, 10'($urandom_range(0, 31)), $urandom, rand_we());
         push(1, 10'($urandom_range(0, 31)), $urandom, rand_we());
      end
      drain();

      push(0, 10'h011, 32'h0, 4'b0000);
      repeat (2) cycle();
      push(1, 10'h005, 32'hA5A5_5A5A, 4'b0000);
      drain();

      push(0, 10'h007, 32'hCAFE_F00D, 4'b0100);
      drain();

      push(0, 10'h009, 32'h0, 4'b0000);
      repeat (2) cycle();
      rst_next = 0; cycle();
      rst_next = 1;
      push(1, 10'h00C, 32'h0, 4'b0000);
      drain();

      repeat (1500) begin
         if (q0.size() == 0 && $urandom_range(0, 3) == 0)
            push(0, 10'($urandom_range(0, 31)), $urandom, rand_we());
         if (q1.size() == 0 && $urandom_range(0, 3) == 0)
            push(1, 10'($urandom_range(0, 31)), $urandom, rand_we());
         rst_next = ($urandom_range(0, 199) != 0);
         cycle();
      end
      rst_next = 1;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
